// File: rtl/cond_logic_it.sv
// cond_logic_it: conditional-execution unit with NBANK independent NZCV flag
// banks and an optional IT (If-Then) block sequencer.
//
// Build option: define COND_LOGIC_IT_EN to build the IT sequencer. Without it
// the IT inputs are ignored, ITActive/ITRemain read 0 and every instruction
// is evaluated with its own Cond field.
//
// Stall semantics: En is the single instruction-advance strobe. With En=0 no
// flag bank is written and no IT slot is consumed; the combinational outputs
// keep describing the instruction currently presented. There is no other
// handshake in this block.
module cond_logic_it #(
  parameter int NBANK  = 2,
  parameter int IT_MAX = 4,
  localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
  localparam int LW    = $clog2(IT_MAX + 1)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              En,
  input  logic [BW-1:0]     BankSel,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  input  logic [1:0]        FlagW,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic              ITStart,
  input  logic [3:0]        ITCond,
  input  logic [IT_MAX-1:0] ITMask,
  input  logic [LW-1:0]     ITLen,
  output logic              CondEx,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              ITActive,
  output logic [LW-1:0]     ITRemain,
  output logic [3:0]        Flags
);

  // NZCV storage, one 4-bit register per bank, packed as {N,Z,C,V}.
  logic [3:0]    bankFlags [NBANK];
  logic [BW-1:0] selIdx;
  logic [3:0]    ec;
  logic          forceFail;
  logic          condPass;

  // Out-of-range bank selects fall back to bank 0.
  always_comb begin
    selIdx = '0;
    if (int'(BankSel) < NBANK) selIdx = BankSel;
  end

  assign Flags = bankFlags[selIdx];

  // Standard ARM condition table; E and F both mean "always".
  function automatic logic condCheck(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cf;
      4'h3:    r = ~cf;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cf & ~z;
      4'h9:    r = ~cf | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

`ifdef COND_LOGIC_IT_EN
  typedef enum logic {IDLE, ACTIVE} itState_t;

  itState_t          itState;
  logic [3:0]        itCondQ;
  logic [IT_MAX-1:0] itMaskQ;   // shifted right each slot; bit 0 is the current slot
  logic [LW-1:0]     itRemainQ;
  logic [LW-1:0]     itLenClamped;
  logic              slotThen;

  assign ITActive = (itState == ACTIVE);
  assign ITRemain = itRemainQ;
  assign slotThen = itMaskQ[0];

  // A zero or oversize length is read as a full-length block.
  always_comb begin
    itLenClamped = ITLen;
    if ((ITLen == '0) || (int'(ITLen) > IT_MAX)) itLenClamped = LW'(IT_MAX);
  end

  // Inside a block the latched base condition applies, inverted on else-slots.
  // An else-slot of an "always" block can never pass.
  always_comb begin
    ec        = Cond;
    forceFail = 1'b0;
    if (ITActive) begin
      ec        = {itCondQ[3:1], itCondQ[0] ^ ~slotThen};
      forceFail = ~slotThen & (itCondQ[3:1] == 3'b111);
    end
  end

  // IT sequencer: opens on a passing IT instruction, closes on the last slot
  // or on a taken branch inside the block.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      itState   <= IDLE;
      itCondQ   <= '0;
      itMaskQ   <= '0;
      itRemainQ <= '0;
    end else if (En) begin
      case (itState)
        IDLE: begin
          if (ITStart && CondEx) begin
            itState   <= ACTIVE;
            itCondQ   <= ITCond;
            itMaskQ   <= ITMask;
            itRemainQ <= itLenClamped;
          end
        end
        ACTIVE: begin
          if (PCSrc || (itRemainQ == LW'(1))) begin
            itState   <= IDLE;
            itRemainQ <= '0;
            itMaskQ   <= '0;
          end else begin
            itRemainQ <= itRemainQ - LW'(1);
            itMaskQ   <= itMaskQ >> 1;
          end
        end
        default: begin
          itState   <= IDLE;
          itRemainQ <= '0;
        end
      endcase
    end
  end
`else
  logic unusedItInputs;

  assign unusedItInputs = ^{ITStart, ITCond, ITMask, ITLen};
  assign ITActive       = 1'b0;
  assign ITRemain       = '0;

  // Without the sequencer every instruction uses its own condition field.
  always_comb begin
    ec        = Cond;
    forceFail = 1'b0;
  end
`endif

  assign condPass = condCheck(ec, Flags);
  assign CondEx   = condPass & ~forceFail;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;

  // Flag banks: only the selected bank is updated, and only by a passing,
  // advancing instruction. Reads see the new value from the next cycle.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      for (int i = 0; i < NBANK; i++) bankFlags[i] <= '0;
    end else if (En && CondEx) begin
      if (FlagW[1]) bankFlags[selIdx][3:2] <= ALUFlags[3:2];
      if (FlagW[0]) bankFlags[selIdx][1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_cond_logic_it.sv
// Table-driven bench for cond_logic_it (NBANK=2, IT_MAX=4). Each table row is
// one clock cycle: inputs are applied after the rising edge and all outputs
// are compared on the falling edge before the row's own edge takes effect.
// IT rows depend on whether COND_LOGIC_IT_EN is defined for the build.
module tb_cond_logic_it;

  logic       clk;
  logic       rst;
  logic       en;
  logic       bank_sel;
  logic       pcs, reg_w, mem_w, no_write;
  logic [1:0] flag_w;
  logic [3:0] cond, alu_flags;
  logic       it_start;
  logic [3:0] it_cond, it_mask;
  logic [2:0] it_len;
  logic       cond_ex, pc_src, reg_write, mem_write, it_active;
  logic [2:0] it_remain;
  logic [3:0] flags;

  cond_logic_it #(.NBANK(2), .IT_MAX(4)) dut (
    .CLK(clk), .rst(rst), .En(en), .BankSel(bank_sel),
    .PCS(pcs), .RegW(reg_w), .MemW(mem_w), .NoWrite(no_write),
    .FlagW(flag_w), .Cond(cond), .ALUFlags(alu_flags),
    .ITStart(it_start), .ITCond(it_cond), .ITMask(it_mask), .ITLen(it_len),
    .CondEx(cond_ex), .PCSrc(pc_src), .RegWrite(reg_write), .MemWrite(mem_write),
    .ITActive(it_active), .ITRemain(it_remain), .Flags(flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {CondEx, PCSrc, RegWrite, MemWrite, ITActive, ITRemain[2:0], Flags[3:0]}
  typedef struct packed {
    logic       rst;
    logic       en;
    logic       bsel;
    logic [3:0] ctl;     // {PCS, RegW, MemW, NoWrite}
    logic [1:0] flagw;
    logic [3:0] cond;
    logic [3:0] alu;
    logic       its;
    logic [3:0] itc;
    logic [3:0] itm;
    logic [2:0] itl;
  } vec_t;

  vec_t        vecs[$];
  string       names[$];
  logic [11:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [11:0] e(input logic cx, input logic [2:0] g,
                                    input logic act, input logic [2:0] rem,
                                    input logic [3:0] f);
    return {cx, g, act, rem, f};
  endfunction

  task automatic add(input string n, input logic r, input logic en_i, input logic bs,
                     input logic [3:0] ctl, input logic [1:0] fw, input logic [3:0] c,
                     input logic [3:0] alu, input logic its, input logic [3:0] itc,
                     input logic [3:0] itm, input logic [2:0] itl, input logic [11:0] exp_v);
    vec_t v;
    v = '{rst: r, en: en_i, bsel: bs, ctl: ctl, flagw: fw, cond: c, alu: alu,
          its: its, itc: itc, itm: itm, itl: itl};
    vecs.push_back(v);
    names.push_back(n);
    exp_q.push_back(exp_v);
  endtask

  // driver
  task automatic drive(input vec_t v);
    rst      = v.rst;
    en       = v.en;
    bank_sel = v.bsel;
    {pcs, reg_w, mem_w, no_write} = v.ctl;
    flag_w    = v.flagw;
    cond      = v.cond;
    alu_flags = v.alu;
    it_start  = v.its;
    it_cond   = v.itc;
    it_mask   = v.itm;
    it_len    = v.itl;
  endtask

  // scoreboard
  task automatic check(input string n);
    logic [11:0] got, exp_v;
    got   = {cond_ex, pc_src, reg_write, mem_write, it_active, it_remain, flags};
    exp_v = exp_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got cx/pc/rw/mw=%b act=%b rem=%0d flags=%b, expected cx/pc/rw/mw=%b act=%b rem=%0d flags=%b",
               n, got[11:8], got[7], got[6:4], got[3:0],
               exp_v[11:8], exp_v[7], exp_v[6:4], exp_v[3:0]);
    end
  endtask

  initial begin
    // reset/basic and gating
    add("reset_eq",        1,0,0,4'b0000,2'b00,4'h0,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b0000));
    add("reset_ne",        1,0,0,4'b0000,2'b00,4'h1,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0000));
    add("gate_nowrite",    1,0,0,4'b1111,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b101,0,3'd0,4'b0000));
    add("gate_all",        1,0,0,4'b1110,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b111,0,3'd0,4'b0000));
    // bank isolation
    add("bank0_write",     1,1,0,4'b0000,2'b11,4'hE,4'b0100,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0000));
    add("bank1_eq",        1,0,1,4'b0000,2'b00,4'h0,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b0000));
    add("bank0_eq",        1,0,0,4'b0000,2'b00,4'h0,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0100));
    // gated and stalled writes
    add("ne_fail_nowrite", 1,1,0,4'b0000,2'b11,4'h1,4'b1000,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b0100));
    add("stall_nowrite",   1,0,0,4'b0000,2'b11,4'hE,4'b1000,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0100));
    add("held_flags",      1,0,0,4'b0000,2'b00,4'h0,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0100));
    // partial writes on bank 1, then the full condition table on it (NZCV=1011)
    add("bank1_cv_write",  1,1,1,4'b0000,2'b01,4'hE,4'b1111,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0000));
    add("bank1_cs",        1,0,1,4'b0000,2'b00,4'h2,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0011));
    add("bank0_vs",        1,0,0,4'b0000,2'b00,4'h6,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b0100));
    add("bank1_nz_write",  1,1,1,4'b0000,2'b10,4'hE,4'b1000,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0011));
    add("bank1_ge",        1,0,1,4'b0000,2'b00,4'hA,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b1011));
    add("bank1_lt",        1,0,1,4'b0000,2'b00,4'hB,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b1011));
    add("bank1_hi",        1,0,1,4'b0000,2'b00,4'h8,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b1011));
    add("bank1_ls",        1,0,1,4'b0000,2'b00,4'h9,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b1011));
    add("bank1_gt",        1,0,1,4'b0000,2'b00,4'hC,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b1011));
    add("bank1_le",        1,0,1,4'b0000,2'b00,4'hD,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b1011));
    add("bank1_mi",        1,0,1,4'b0000,2'b00,4'h4,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b1011));
    add("bank1_pl",        1,0,1,4'b0000,2'b00,4'h5,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b1011));
    add("bank1_cc",        1,0,1,4'b0000,2'b00,4'h3,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b1011));
    add("bank1_vc",        1,0,1,4'b0000,2'b00,4'h7,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b1011));
    add("bank0_f_al",      1,0,0,4'b0000,2'b00,4'hF,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0100));
`ifdef COND_LOGIC_IT_EN
    // IT block EQ, mask 0101, length 4 (bank0 Z=1): then/else/then/else
    add("it_start",        1,1,0,4'b0100,2'b00,4'hE,4'h0,1,4'h0,4'b0101,3'd4, e(1,3'b010,0,3'd0,4'b0100));
    add("it_slot0",        1,1,0,4'b0100,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b010,1,3'd4,4'b0100));
    add("it_slot1",        1,1,0,4'b0100,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,1,3'd3,4'b0100));
    add("it_slot2",        1,1,0,4'b0100,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b010,1,3'd2,4'b0100));
    add("it_slot3",        1,1,0,4'b0100,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,1,3'd1,4'b0100));
    add("it_done",         1,0,0,4'b0100,2'b00,4'h1,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b0100));
    // length-3 block: nested IT ignored, stall holds, branch flushes
    add("fl_start",        1,1,0,4'b0000,2'b00,4'hE,4'h0,1,4'h0,4'b0111,3'd3, e(1,3'b000,0,3'd0,4'b0100));
    add("fl_nested",       1,1,0,4'b0000,2'b00,4'hE,4'h0,1,4'h1,4'b0000,3'd2, e(1,3'b000,1,3'd3,4'b0100));
    add("fl_stall",        1,0,0,4'b0000,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,1,3'd2,4'b0100));
    add("fl_stall_held",   1,0,0,4'b0000,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,1,3'd2,4'b0100));
    add("fl_branch",       1,1,0,4'b1000,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b100,1,3'd2,4'b0100));
    add("fl_after",        1,0,0,4'b0000,2'b00,4'h0,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0100));
    // AL block with ITLen=0 (clamped to 4); else-slots forced off; reset in slot 2
    add("rs_start",        1,1,0,4'b0000,2'b00,4'hE,4'h0,1,4'hE,4'b0010,3'd0, e(1,3'b000,0,3'd0,4'b0100));
    add("rs_else_al",      1,1,0,4'b0100,2'b11,4'hE,4'b1111,0,4'h0,4'h0,3'd0, e(0,3'b000,1,3'd4,4'b0100));
    add("rs_then_al",      1,1,0,4'b0000,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,1,3'd3,4'b0100));
    add("rs_reset",        0,1,0,4'b0000,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,1,3'd2,4'b0100));
    add("rs_after",        1,0,0,4'b0000,2'b00,4'h1,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0000));
    // failing IT instruction does not open a block
    add("nb_start_fail",   1,1,0,4'b0000,2'b00,4'h0,4'h0,1,4'hE,4'b1111,3'd2, e(0,3'b000,0,3'd0,4'b0000));
    add("nb_after",        1,0,0,4'b0000,2'b00,4'h0,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b0000));
`else
    // sequencer not built: IT inputs have no effect
    add("off_start",       1,1,0,4'b0100,2'b00,4'hE,4'h0,1,4'h0,4'b0101,3'd4, e(1,3'b010,0,3'd0,4'b0100));
    add("off_slot1",       1,1,0,4'b0100,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b010,0,3'd0,4'b0100));
    add("off_slot2",       1,1,0,4'b0100,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b010,0,3'd0,4'b0100));
    add("off_slot3",       1,1,0,4'b0100,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b010,0,3'd0,4'b0100));
    add("off_ne",          1,0,0,4'b0100,2'b00,4'h1,4'h0,0,4'h0,4'h0,3'd0, e(0,3'b000,0,3'd0,4'b0100));
    add("off_reset",       0,1,0,4'b0000,2'b00,4'hE,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0100));
    add("off_after",       1,0,0,4'b0000,2'b00,4'h1,4'h0,0,4'h0,4'h0,3'd0, e(1,3'b000,0,3'd0,4'b0000));
`endif

    // initial reset
    drive('0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check(names[i]);
    end
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
